// File: rtl/led_snake_pkg.sv
// Shared types, constants and pixel helpers for the LED snake animator.
package led_snake_pkg;

  localparam int NUM_LEDS = 8;
  localparam int PIX_W    = 24;

  typedef logic [2:0] pos_t;

  typedef struct packed {
    logic valid;
    pos_t pos;
  } hist_t;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Per-channel right shift of a GRB word; channels never bleed into each other.
  function automatic logic [PIX_W-1:0] dim(input logic [PIX_W-1:0] pix, input logic [2:0] k);
    dim = {pix[23:16] >> k, pix[15:8] >> k, pix[7:0] >> k};
  endfunction

  function automatic logic [3:0] clamp_len(input logic [3:0] len);
    if (len == 4'd0) begin
      clamp_len = 4'd1;
    end else if (len > 4'd8) begin
      clamp_len = 4'd8;
    end else begin
      clamp_len = len;
    end
  endfunction

  function automatic logic [15:0] clamp_step(input logic [15:0] step);
    clamp_step = (step == 16'd0) ? 16'd1 : step;
  endfunction

endpackage

// File: rtl/led_snake_renderer.sv
// Combinational frame renderer: history entries, length and colour to eight GRB pixels.
module led_snake_renderer
  import led_snake_pkg::*;
(
  input  hist_t [NUM_LEDS-1:0]            hist,
  input  logic  [3:0]                     len,
  input  logic  [PIX_W-1:0]               color,
  output logic  [NUM_LEDS-1:0][PIX_W-1:0] pix
);

  // Walk segments from the tail toward the head so the lowest k overwrites last.
  always_comb begin
    pix = '0;
    for (int i = 0; i < NUM_LEDS; i++) begin
      for (int k = NUM_LEDS - 1; k >= 0; k--) begin
        if (hist[k].valid && (hist[k].pos == 3'(i)) && (4'(k) < len)) begin
          pix[i] = dim(color, 3'(k));
        end
      end
    end
  end

endmodule

// File: rtl/led_snake_animator.sv
// Snake animation sequencer feeding the eight frame words of the LED transmitter.
// Build option: define LED_SNAKE_BOUNCE_EN to reflect at the strip ends instead of wrapping.
//
// state | meaning
// IDLE  | all LEDs dark, history empty, config writes go straight to active
// RUN   | snake shown, steps every step_act refresh requests
module led_snake_animator
  import led_snake_pkg::*;
#(
  parameter logic [PIX_W-1:0] DEF_COLOR = 24'h00FF00,
  parameter logic [3:0]       DEF_LEN   = 4'd3,
  parameter logic [15:0]      DEF_STEP  = 16'd30
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             enable,
  input  logic             dir,
  input  logic             cfg_wr,
  input  logic [PIX_W-1:0] cfg_color,
  input  logic [3:0]       cfg_len,
  input  logic [15:0]      cfg_step,
  input  logic             new_frames_set_rqst,
  output logic [PIX_W-1:0] led0,
  output logic [PIX_W-1:0] led1,
  output logic [PIX_W-1:0] led2,
  output logic [PIX_W-1:0] led3,
  output logic [PIX_W-1:0] led4,
  output logic [PIX_W-1:0] led5,
  output logic [PIX_W-1:0] led6,
  output logic [PIX_W-1:0] led7,
  output logic [2:0]       head_pos,
  output logic             step_pulse
);

  state_t state;
  logic   dir_q;
  logic [15:0] frame_cnt;

  logic [PIX_W-1:0] color_sh, color_act, color_nxt;
  logic [3:0]       len_sh, len_act, len_nxt;
  logic [15:0]      step_sh, step_act, step_nxt;

  hist_t [NUM_LEDS-1:0] hist, hist_nxt;
  hist_t                head_ent;
  pos_t                 head_nxt;
  logic                 dir_nxt;

  logic go_run, go_idle, at_tc, boundary;
  logic [3:0]  len_in;
  logic [15:0] step_in;
  logic [NUM_LEDS-1:0][PIX_W-1:0] pix_nxt;

  assign len_in  = clamp_len(cfg_len);
  assign step_in = clamp_step(cfg_step);

  // Next-value datapath; the frame is rendered from these so the LED registers
  // change on the same edge as the history they depict.
  always_comb begin
    go_run    = (state == IDLE) && enable;
    go_idle   = (state == RUN) && !enable;
    at_tc     = (frame_cnt == (step_act - 16'd1));
    boundary  = (state == RUN) && enable && new_frames_set_rqst && at_tc;
    color_nxt = color_act;
    len_nxt   = len_act;
    step_nxt  = step_act;
    head_nxt  = head_pos;
    dir_nxt   = dir_q;
    hist_nxt  = hist;
    head_ent  = '0;

    if (state == IDLE) begin
      color_nxt = cfg_wr ? cfg_color : color_sh;
      len_nxt   = cfg_wr ? len_in    : len_sh;
      step_nxt  = cfg_wr ? step_in   : step_sh;
    end

    if (go_run) begin
      hist_nxt           = '0;
      hist_nxt[0].valid  = 1'b1;
      hist_nxt[0].pos    = head_pos;
      dir_nxt            = dir;
    end else if (go_idle) begin
      hist_nxt = '0;
    end else if (boundary) begin
      color_nxt = color_sh;
      len_nxt   = len_sh;
      step_nxt  = step_sh;
`ifdef LED_SNAKE_BOUNCE_EN
      if (!dir_q && (head_pos == 3'd7)) begin
        head_nxt = 3'd6;
        dir_nxt  = 1'b1;
      end else if (dir_q && (head_pos == 3'd0)) begin
        head_nxt = 3'd1;
        dir_nxt  = 1'b0;
      end else begin
        head_nxt = dir_q ? (head_pos - 3'd1) : (head_pos + 3'd1);
      end
`else
      head_nxt = dir_q ? (head_pos - 3'd1) : (head_pos + 3'd1);
      dir_nxt  = dir;
`endif
      head_ent.valid = 1'b1;
      head_ent.pos   = head_nxt;
      hist_nxt       = {hist[NUM_LEDS-2:0], head_ent};
    end
  end

  led_snake_renderer u_renderer (
    .hist  (hist_nxt),
    .len   (len_nxt),
    .color (color_nxt),
    .pix   (pix_nxt)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= IDLE;
      dir_q      <= 1'b0;
      frame_cnt  <= '0;
      color_sh   <= DEF_COLOR;
      len_sh     <= DEF_LEN;
      step_sh    <= DEF_STEP;
      color_act  <= DEF_COLOR;
      len_act    <= DEF_LEN;
      step_act   <= DEF_STEP;
      hist       <= '0;
      head_pos   <= '0;
      step_pulse <= 1'b0;
      led0       <= '0;
      led1       <= '0;
      led2       <= '0;
      led3       <= '0;
      led4       <= '0;
      led5       <= '0;
      led6       <= '0;
      led7       <= '0;
    end else begin
      if (cfg_wr) begin
        color_sh <= cfg_color;
        len_sh   <= len_in;
        step_sh  <= step_in;
      end
      color_act  <= color_nxt;
      len_act    <= len_nxt;
      step_act   <= step_nxt;
      hist       <= hist_nxt;
      head_pos   <= head_nxt;
      dir_q      <= dir_nxt;
      step_pulse <= boundary;
      led0       <= pix_nxt[0];
      led1       <= pix_nxt[1];
      led2       <= pix_nxt[2];
      led3       <= pix_nxt[3];
      led4       <= pix_nxt[4];
      led5       <= pix_nxt[5];
      led6       <= pix_nxt[6];
      led7       <= pix_nxt[7];

      case (state)
        IDLE: begin
          if (enable) begin
            state     <= RUN;
            frame_cnt <= '0;
          end
        end
        RUN: begin
          if (!enable) begin
            state     <= IDLE;
            frame_cnt <= '0;
          end else if (new_frames_set_rqst) begin
            frame_cnt <= at_tc ? 16'd0 : (frame_cnt + 16'd1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_led_snake_animator.sv
// Scoreboard bench for led_snake_animator: directed scenarios plus random traffic vs a queue-based model.
module tb_led_snake_animator;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        enable = 1'b0, dir = 1'b0, cfg_wr = 1'b0, rqst = 1'b0;
  logic [23:0] cfg_color = '0;
  logic [3:0]  cfg_len = '0;
  logic [15:0] cfg_step = '0;
  logic [23:0] led0, led1, led2, led3, led4, led5, led6, led7;
  logic [2:0]  head_pos;
  logic        step_pulse;

  always #5 clk = ~clk;

  led_snake_animator dut (
    .clk(clk), .rstn(rstn), .enable(enable), .dir(dir), .cfg_wr(cfg_wr),
    .cfg_color(cfg_color), .cfg_len(cfg_len), .cfg_step(cfg_step),
    .new_frames_set_rqst(rqst),
    .led0(led0), .led1(led1), .led2(led2), .led3(led3),
    .led4(led4), .led5(led5), .led6(led6), .led7(led7),
    .head_pos(head_pos), .step_pulse(step_pulse)
  );

  logic [7:0][23:0] dut_frame;
  assign dut_frame = {led7, led6, led5, led4, led3, led2, led1, led0};

  typedef struct packed {
    logic [7:0][23:0] leds;
    logic [2:0]       head;
    logic             sp;
  } exp_t;

  exp_t exp_q[$];
  int total = 0;
  int bad = 0;

  task automatic chk(input string name, input logic [191:0] act, input logic [191:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %0h want %0h", name, $time, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  bit          m_run;
  int          m_head, m_cnt, m_len, m_step, s_len, s_step;
  bit          m_dir;
  logic [23:0] m_col, s_col;
  int          trail[$];   // head first, most recent positions

  function automatic logic [23:0] dimc(input logic [23:0] c, input int k);
    return {c[23:16] >> k, c[15:8] >> k, c[7:0] >> k};
  endfunction

  function automatic void m_reset();
    m_run = 0; m_head = 0; m_dir = 0; m_cnt = 0;
    m_len = 3; m_step = 30; s_len = 3; s_step = 30;
    m_col = 24'h00FF00; s_col = 24'h00FF00;
    trail.delete();
  endfunction

  function automatic logic [7:0][23:0] m_frame();
    logic [7:0][23:0] f;
    bit hit;
    f = '0;
    for (int i = 0; i < 8; i++) begin
      hit = 0;
      for (int k = 0; k < trail.size() && k < m_len; k++) begin
        if (!hit && trail[k] == i) begin
          f[i] = dimc(m_col, k);
          hit = 1;
        end
      end
    end
    return f;
  endfunction

  function automatic void m_move(input bit d);
`ifdef LED_SNAKE_BOUNCE_EN
    if (!m_dir && m_head == 7) begin m_head = 6; m_dir = 1; end
    else if (m_dir && m_head == 0) begin m_head = 1; m_dir = 0; end
    else m_head = m_dir ? m_head - 1 : m_head + 1;
`else
    m_head = (m_head + (m_dir ? 7 : 1)) % 8;
    m_dir  = d;
`endif
  endfunction

  // One clock of stimulus: drive at negedge, advance model, queue expected outputs.
  task automatic cyc(input bit en, input bit d, input bit wr, input logic [23:0] col,
                     input logic [3:0] ln, input logic [15:0] st, input bit rq);
    exp_t e;
    bit sp;
    int nl, ns;
    sp = 0;
    @(negedge clk);
    enable = en; dir = d; cfg_wr = wr; cfg_color = col; cfg_len = ln; cfg_step = st; rqst = rq;
    nl = (ln == 0) ? 1 : (ln > 8) ? 8 : int'(ln);
    ns = (st == 0) ? 1 : int'(st);
    if (!m_run) begin
      if (wr) begin s_col = col; s_len = nl; s_step = ns; end
      m_col = s_col; m_len = s_len; m_step = s_step;
      if (en) begin
        m_run = 1; m_dir = d; m_cnt = 0;
        trail.delete(); trail.push_back(m_head);
      end
    end else begin
      if (!en) begin
        m_run = 0; m_cnt = 0; trail.delete();
      end else if (rq) begin
        if (m_cnt == m_step - 1) begin
          sp = 1; m_cnt = 0;
          m_col = s_col; m_len = s_len; m_step = s_step;
          m_move(d);
          trail.push_front(m_head);
          if (trail.size() > 8) void'(trail.pop_back());
        end else begin
          m_cnt++;
        end
      end
      if (wr) begin s_col = col; s_len = nl; s_step = ns; end
    end
    e.leds = m_frame();
    e.head = 3'(m_head);
    e.sp   = sp;
    exp_q.push_back(e);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #3;
    rstn = 0; enable = 0; dir = 0; cfg_wr = 0; rqst = 0;
    #1;
    chk("async_reset_frame", dut_frame, '0);
    chk("async_reset_head", head_pos, 0);
    chk("async_reset_step", step_pulse, 0);
    m_reset();
    @(negedge clk);
    rstn = 1;
  endtask

  // ---------------- monitor ----------------
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("frame", dut_frame, e.leds);
        chk("head_pos", head_pos, e.head);
        chk("step_pulse", step_pulse, e.sp);
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    bit cur_en, cur_dir;
    logic [7:0][23:0] f;
    m_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("reset_frame", dut_frame, '0);
    chk("reset_head", head_pos, 0);
    chk("reset_step", step_pulse, 0);
    @(negedge clk);
    rstn = 1;

    // 1: defaults, 30 refresh pulses spread over 60 cycles
    cyc(1, 0, 0, '0, '0, '0, 0);
    for (int i = 0; i < 60; i++) cyc(1, 0, 0, '0, '0, '0, (i % 2) == 1);
    @(posedge clk); #2;
    chk("t1_head", head_pos, 1);
    chk("t1_led1", led1, 24'h00FF00);
    chk("t1_led0", led0, 24'h007F00);
    chk("t1_pulse", step_pulse, 1);

    // 2: step 1, len 3, walk head to 7 then one more step
    cyc(0, 0, 0, '0, '0, '0, 0);
    cyc(0, 0, 1, 24'h00FF00, 4'd3, 16'd1, 0);
    cyc(1, 0, 0, '0, '0, '0, 0);
    for (int i = 0; i < 6; i++) cyc(1, 0, 0, '0, '0, '0, 1);
    cyc(1, 0, 0, '0, '0, '0, 1);
    @(posedge clk); #2;
`ifdef LED_SNAKE_BOUNCE_EN
    chk("t2_head", head_pos, 6);
    chk("t2_led6", led6, 24'h00FF00);
    chk("t2_led7", led7, 24'h007F00);
`else
    chk("t2_head", head_pos, 0);
    chk("t2_led0", led0, 24'h00FF00);
    chk("t2_led7", led7, 24'h007F00);
    chk("t2_led6", led6, 24'h003F00);
`endif

    // 3: red, len 0, step 0 written in RUN
    cyc(1, 0, 1, 24'hFF0000, 4'd0, 16'd0, 0);
    cyc(1, 0, 0, '0, '0, '0, 1);
    cyc(1, 0, 0, '0, '0, '0, 1);
    @(posedge clk); #2;
    f = '0;
    f[m_head] = 24'hFF0000;
    chk("t3_lone_pixel", dut_frame, f);

    // 4: length 12 clamps to 8
    cyc(1, 0, 1, 24'hFF8040, 4'd12, 16'd1, 0);
    for (int i = 0; i < 9; i++) cyc(1, 0, 0, '0, '0, '0, 1);
    @(posedge clk); #2;
`ifndef LED_SNAKE_BOUNCE_EN
    for (int k = 0; k < 8; k++) chk("t4_segment", dut_frame[(m_head - k + 8) % 8], dimc(24'hFF8040, k));
`endif

    // 5: disable then re-enable resumes at the held head
    cyc(0, 0, 0, '0, '0, '0, 1);
    @(posedge clk); #2;
    chk("t5_dark", dut_frame, '0);
    chk("t5_head_held", head_pos, 3'(m_head));
    cyc(1, 0, 0, '0, '0, '0, 0);
    @(posedge clk); #2;
    f = '0;
    f[m_head] = 24'hFF8040;
    chk("t5_restart", dut_frame, f);

    // 6: refresh requests in IDLE, then async reset mid-run
    cyc(0, 1, 0, '0, '0, '0, 1);
    for (int i = 0; i < 4; i++) cyc(0, 1, 0, '0, '0, '0, 1);
    cyc(1, 1, 0, '0, '0, '0, 0);
    for (int i = 0; i < 5; i++) cyc(1, 1, 0, '0, '0, '0, 1);
    do_reset();

    // random traffic
    cur_en = 1; cur_dir = 0;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 999) == 0) do_reset();
      if ($urandom_range(0, 59) == 0) cur_en = !cur_en;
      if ($urandom_range(0, 19) == 0) cur_dir = 1'($urandom);
      cyc(cur_en, cur_dir, $urandom_range(0, 29) == 0, 24'($urandom),
          4'($urandom_range(0, 15)), 16'($urandom_range(0, 3)), $urandom_range(0, 2) == 0);
    end

    repeat (2) @(posedge clk);
    #3;
    chk("queue_drained", 192'(exp_q.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
